minmax_window_ctrl: RTL

Sequencer for the shared 32-bit min/max tracking datapath. It accepts a stream of samples over a valid/ready handshake and groups them into fixed windows of WIN_LEN samples. For each sample it drives the datapath's clear and load enables, and presents the window's min/max as a held result over a valid/ready handshake. It sits between the sample source and the min/max register datapath and owns all datapath control.

---
 rtl/minmax_pkg.sv | 14 +
 rtl/minmax_cmp_unit.sv | 21 ++
 rtl/minmax_window_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/minmax_pkg.sv
// Shared types and defaults for the min/max window controller and its compare unit.
package minmax_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int WIN_LEN_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/minmax_cmp_unit.sv
// Unsigned compare deciding whether an incoming sample replaces the datapath min and/or max.
module minmax_cmp_unit
    import minmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] dp_min,
    input  logic [DATA_W-1:0] dp_max,
    input  logic              first,
    output logic              min_ld,
    output logic              max_ld
);

    // The first sample of a window seeds both registers; equal values never load.
    always_comb begin
        min_ld = first || (in_data < dp_min);
        max_ld = first || (in_data > dp_max);
    end

endmodule

// File: rtl/minmax_window_ctrl.sv
// Window sequencer: groups WIN_LEN handshaked samples, drives the min/max datapath enables,
// and holds the window result until the consumer takes it.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle datapath clear, sample counter reset
// ACCEPT | taking samples, loading min/max as needed
// DONE   | result presented until res_ready
module minmax_window_ctrl
    import minmax_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dp_clr,
    output logic              dp_min_ld,
    output logic              dp_max_ld,
    output logic [DATA_W-1:0] dp_data,
    input  logic [DATA_W-1:0] dp_min,
    input  logic [DATA_W-1:0] dp_max,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max,
    output logic              busy,
    output logic [15:0]       win_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             take;
    logic             cmp_min_ld;
    logic             cmp_max_ld;

    // Abort wins over a same-cycle handshake, so the sample is neither loaded nor counted.
    assign take = (state == ST_ACCEPT) && in_valid && !abort;

    minmax_cmp_unit #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .in_data (in_data),
        .dp_min  (dp_min),
        .dp_max  (dp_max),
        .first   (cnt == '0),
        .min_ld  (cmp_min_ld),
        .max_ld  (cmp_max_ld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_next = abort ? ST_IDLE : ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (take && (cnt == CNT_LAST)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) state_next = start ? ST_CLEAR : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_ACCEPT);
        dp_clr    = (state == ST_CLEAR);
        dp_min_ld = take && cmp_min_ld;
        dp_max_ld = take && cmp_max_ld;
        dp_data   = in_data;
        res_valid = (state == ST_DONE);
        res_min   = res_valid ? dp_min : '0;
        res_max   = res_valid ? dp_max : '0;
        busy      = (state != ST_IDLE);
    end

    // The last sample wraps the counter to 0 so it stays within 0..WIN_LEN-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
        end else if ((state == ST_DONE) && res_ready && (win_cnt != 16'hFFFF)) begin
            win_cnt <= win_cnt + 16'd1;
        end
    end

endmodule
